// File: rtl/spi_rx_18b.sv
// SPI mode-0 slave receiver: oversamples sclk/mosi/cs_n on clk and assembles
// one LARGO-bit word per cs_n window, MSB first.
module spi_rx_18b #(
  parameter int LARGO = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             cs_n,
  output logic [LARGO-1:0] dato,
  output logic             valido,
  output logic             err_trama,
  output logic             ocupado
);

  localparam int CW = $clog2(LARGO + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic             sclk_prev_q;
  logic [LARGO-1:0] shreg_q, shreg_d;
  logic [LARGO-1:0] dato_q, dato_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valido_q, valido_d;
  logic             err_q, err_d;
  logic             ocupado_q;

  logic sclk_s, mosi_s, cs_s, sclk_rise;

  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dato_q      <= '0;
      valido_q    <= 1'b0;
      err_q       <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dato_q      <= dato_d;
      valido_q    <= valido_d;
      err_q       <= err_d;
      ocupado_q   <= (state_q != IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    dato_d   = dato_q;
    valido_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        shreg_d = '0;
        cnt_d   = '0;
        if (!cs_s) state_d = SHIFT;
      end
      SHIFT: begin
        // A cs_n release takes priority over a coincident sclk edge.
        if (cs_s) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[LARGO-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(LARGO - 1)) state_d = DONE;
        end
      end
      DONE: begin
        dato_d   = shreg_q;
        valido_d = 1'b1;
        state_d  = WAIT_CS;
      end
      WAIT_CS: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dato      = dato_q;
  assign valido    = valido_q;
  assign err_trama = err_q;
  assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_spi_rx_18b.sv
// Scoreboard bench for spi_rx_18b: directed scenarios plus randomized frames;
// a monitor pops expected outcomes whenever valido or err_trama pulses.
module tb_spi_rx_18b;

  localparam int L = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         cs_n = 1'b1;
  logic [L-1:0] dato;
  logic         valido, err_trama, ocupado;

  spi_rx_18b #(.LARGO(L)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .dato(dato), .valido(valido), .err_trama(err_trama), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    logic [L-1:0] data;
    bit           chk_lat;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           last_rise = 0;
  logic [L-1:0] exp_dato = '0;
  bit           ocu_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a frame of nb bits yields the first L bits as a word
  // when nb >= L, otherwise an aborted-frame error with dato untouched.
  task automatic expect_frame(input logic [L-1:0] word, input int nb);
    exp_t e;
    e.is_err  = (nb < L);
    e.data    = word;
    e.chk_lat = (nb == L);
    sb.push_back(e);
  endtask

  task automatic send_bits(input logic [L-1:0] word, input int nb, input int hi, input int lo);
    for (int i = 0; i < nb; i++) begin
      mosi = (i < L) ? word[L-1-i] : 1'($urandom);
      wait_cyc(lo);
      sclk = 1'b1;
      last_rise = cyc;
      wait_cyc(hi);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [L-1:0] word, input int nb, input int hi, input int lo, input int gap);
    expect_frame(word, nb);
    cs_n = 1'b0;
    wait_cyc(3);
    send_bits(word, nb, hi, lo);
    wait_cyc(lo + 3);
    cs_n = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic reset_pulse(input bit drop_cs);
    rst = 1'b1;
    if (drop_cs) cs_n = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_dato = '0;
    @(negedge clk);
    chk("rst_dato", 32'(dato), 32'h0);
    chk("rst_valido", 32'(valido), 32'h0);
    chk("rst_err", 32'(err_trama), 32'h0);
    chk("rst_ocupado", 32'(ocupado), 32'h0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (ocu_pending) begin
        chk("ocupado_after_err", 32'(ocupado), 32'h0);
        ocu_pending = 1'b0;
      end
      if (valido || err_trama) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'h0, valido, err_trama}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_kind", {30'h0, valido, err_trama}, e.is_err ? 32'h1 : 32'h2);
          if (e.is_err) begin
            chk("dato_held", 32'(dato), 32'(exp_dato));
            ocu_pending = 1'b1;
          end else begin
            chk("dato", 32'(dato), 32'(e.data));
            chk("ocupado_at_valid", 32'(ocupado), 32'h1);
            if (e.chk_lat) chk("latency", 32'(cyc - last_rise), 32'd4);
            exp_dato = e.data;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("init_dato", 32'(dato), 32'h0);
    chk("init_valido", 32'(valido), 32'h0);
    chk("init_err", 32'(err_trama), 32'h0);
    chk("init_ocupado", 32'(ocupado), 32'h0);
    wait_cyc(2);

    frame(18'h2B3C1, L, 4, 4, 10);       // basic frame
    frame(18'h3FFFF, L, 4, 4, 4);        // back-to-back
    frame(18'h00001, L, 4, 4, 10);
    frame(18'h12345, 10, 4, 4, 10);      // short frame
    frame(18'h15555, 22, 4, 4, 10);      // excess bits
    frame(18'h2AAAA, L, 3, 3, 10);       // minimum sclk timing

    // Reset mid-frame with cs_n released together with rst.
    cs_n = 1'b0;
    wait_cyc(3);
    send_bits(18'h3A5A5, 9, 4, 4);
    reset_pulse(1'b1);
    wait_cyc(20);

    // Reset mid-frame with cs_n held low: the frame restarts after release.
    cs_n = 1'b0;
    wait_cyc(3);
    send_bits(18'h0F0F0, 9, 4, 4);
    reset_pulse(1'b0);
    wait_cyc(4);
    expect_frame(18'h1F0F3, L);
    send_bits(18'h1F0F3, L, 4, 4);
    wait_cyc(7);
    cs_n = 1'b1;
    wait_cyc(10);

    for (int n = 0; n < 20; n++) begin
      logic [L-1:0] w;
      int           nb;
      int           sel;
      w   = L'($urandom);
      sel = $urandom_range(0, 2);
      nb  = (sel == 0) ? L : (sel == 1) ? L + $urandom_range(1, 4) : $urandom_range(1, L - 1);
      frame(w, nb, $urandom_range(3, 6), $urandom_range(3, 6), $urandom_range(4, 8));
    end

    wait_cyc(20);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
